fib_result_checker: RTL and testbench



---
 rtl/fib_chk_pkg.sv | 15 +
 rtl/pc_halt_detector.sv | 70 +++++++
 rtl/fib_result_checker.sv | 175 +++++++++++++++++
 tb/tb_fib_result_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_chk_pkg.sv
// Shared types and constants for the Fibonacci result checker.
package fib_chk_pkg;

  typedef enum logic [1:0] {
    ST_WATCH,
    ST_SCAN,
    ST_DONE
  } chk_state_t;

  localparam logic [7:0] NO_ERR_IDX = 8'hFF;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/pc_halt_detector.sv
// Detects the CPU parking on its terminal self-loop; optional watchdog counter
// enabled by FIB_RESULT_CHECKER_TIMEOUT_EN.
module pc_halt_detector #(
  parameter int          PC_W           = 32,
  parameter int unsigned HALT_PC        = 104,
  parameter int          STABLE_CYCLES  = 10,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            active,
  input  logic [PC_W-1:0] pc_i,
  output logic            halt_pulse,
  output logic            timeout_pulse
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);
  localparam logic [SC_W-1:0] SC_PRE = SC_W'(STABLE_CYCLES - 1);
  localparam logic [PC_W-1:0] HALT_PC_V = PC_W'(HALT_PC);

  logic [PC_W-1:0] prev_pc_reg;
  logic [SC_W-1:0] stable_cnt_reg, stable_cnt_next;
  logic            at_halt;

  // The first cycle at HALT_PC never counts: prev_pc still holds the old PC.
  assign at_halt = (pc_i == HALT_PC_V) && (pc_i == prev_pc_reg);

  always_comb begin
    stable_cnt_next = '0;
    if (at_halt) begin
      stable_cnt_next = (stable_cnt_reg == SC_MAX) ? stable_cnt_reg : stable_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pc_reg    <= '1;
      stable_cnt_reg <= '0;
    end else begin
      prev_pc_reg    <= pc_i;
      stable_cnt_reg <= stable_cnt_next;
    end
  end

  // Fires in the cycle whose edge brings stable_cnt to STABLE_CYCLES.
  assign halt_pulse = active && at_halt && (stable_cnt_reg == SC_PRE);

`ifdef FIB_RESULT_CHECKER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_PRE = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_reg <= '0;
    end else if (to_cnt_reg != TO_MAX) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  assign timeout_pulse = active && (to_cnt_reg == TO_PRE);
`else
  // No watchdog in this build; TIMEOUT_CYCLES has no effect.
  assign timeout_pulse = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: rtl/fib_result_checker.sv
// Waits for the CPU halt loop, then scans the result table against fib(k).
// Optional watchdog: define FIB_RESULT_CHECKER_TIMEOUT_EN.
module fib_result_checker
  import fib_chk_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int          ADDR_W         = 32,
  parameter int          N_TERMS        = 10,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned HALT_PC        = 104,
  parameter int          STABLE_CYCLES  = 10,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_i,
  output logic              chk_rd_en_o,
  output logic [ADDR_W-1:0] chk_addr_o,
  input  logic [DATA_W-1:0] chk_rdata_i,
  output logic              halted_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [7:0]        err_cnt_o,
  output logic [7:0]        first_err_idx_o
);

  localparam logic [ADDR_W-1:0] BASE_V   = ADDR_W'(BASE_ADDR);
  localparam logic [7:0]        LAST_IDX = 8'(N_TERMS - 1);
  localparam logic [DATA_W-1:0] FIB_ONE  = DATA_W'(1);

  chk_state_t state_reg, state_next;
  logic                 rd_en_reg, rd_en_next;
  logic [ADDR_W-1:0]    addr_reg, addr_next;
  logic [7:0]           issue_idx_reg, issue_idx_next;
  logic                 cmp_valid_reg, cmp_valid_next;
  logic [7:0]           cmp_idx_reg, cmp_idx_next;
  logic [DATA_W-1:0]    fib_a_reg, fib_a_next, fib_b_reg, fib_b_next;
  logic                 halted_reg, halted_next, done_reg, done_next;
  logic                 pass_reg, pass_next, timeout_reg, timeout_next;
  logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic [7:0]           first_err_reg, first_err_next;
  logic [DATA_W-1:0]    fib_sum, expected;
  logic                 halt_pulse, timeout_pulse;

  pc_halt_detector #(
    .PC_W           (32),
    .HALT_PC        (HALT_PC),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_detector (
    .clk           (clk),
    .rst           (rst),
    .active        (state_reg == ST_WATCH),
    .pc_i          (pc_i),
    .halt_pulse    (halt_pulse),
    .timeout_pulse (timeout_pulse)
  );

  // Expectations come only from the a/b pair, so a bad word cannot skew later ones.
  assign fib_sum  = fib_a_reg + fib_b_reg;
  assign expected = (cmp_idx_reg < 8'd2) ? FIB_ONE : fib_sum;

  always_comb begin
    state_next     = state_reg;
    rd_en_next     = rd_en_reg;
    addr_next      = addr_reg;
    issue_idx_next = issue_idx_reg;
    cmp_valid_next = 1'b0;
    cmp_idx_next   = cmp_idx_reg;
    fib_a_next     = fib_a_reg;
    fib_b_next     = fib_b_reg;
    halted_next    = halted_reg;
    done_next      = done_reg;
    pass_next      = pass_reg;
    timeout_next   = timeout_reg;
    err_cnt_next   = err_cnt_reg;
    first_err_next = first_err_reg;
    case (state_reg)
      ST_WATCH: begin
        // Halt takes priority over a timeout landing in the same cycle.
        if (halt_pulse) begin
          halted_next = 1'b1;
          if (N_TERMS == 0) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            pass_next  = 1'b1;
          end else begin
            state_next     = ST_SCAN;
            rd_en_next     = 1'b1;
            addr_next      = BASE_V;
            issue_idx_next = '0;
          end
        end else if (timeout_pulse) begin
          state_next   = ST_DONE;
          timeout_next = 1'b1;
          done_next    = 1'b1;
          pass_next    = 1'b0;
        end
      end
      ST_SCAN: begin
        if (rd_en_reg) begin
          cmp_valid_next = 1'b1;
          cmp_idx_next   = issue_idx_reg;
          if (issue_idx_reg == LAST_IDX) begin
            rd_en_next = 1'b0;
          end else begin
            issue_idx_next = issue_idx_reg + 1'b1;
            addr_next      = addr_reg + ADDR_W'(4);
          end
        end
        if (cmp_valid_reg) begin
          if (chk_rdata_i != expected) begin
            if (err_cnt_reg != ERR_CNT_MAX) err_cnt_next = err_cnt_reg + 1'b1;
            if (first_err_reg == NO_ERR_IDX) first_err_next = cmp_idx_reg;
          end
          if (cmp_idx_reg >= 8'd2) begin
            fib_a_next = fib_b_reg;
            fib_b_next = fib_sum;
          end
          if (cmp_idx_reg == LAST_IDX) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            pass_next  = (err_cnt_next == '0) && !timeout_reg;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_WATCH;
      rd_en_reg     <= 1'b0;
      addr_reg      <= '0;
      issue_idx_reg <= '0;
      cmp_valid_reg <= 1'b0;
      cmp_idx_reg   <= '0;
      fib_a_reg     <= FIB_ONE;
      fib_b_reg     <= FIB_ONE;
      halted_reg    <= 1'b0;
      done_reg      <= 1'b0;
      pass_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      err_cnt_reg   <= '0;
      first_err_reg <= NO_ERR_IDX;
    end else begin
      state_reg     <= state_next;
      rd_en_reg     <= rd_en_next;
      addr_reg      <= addr_next;
      issue_idx_reg <= issue_idx_next;
      cmp_valid_reg <= cmp_valid_next;
      cmp_idx_reg   <= cmp_idx_next;
      fib_a_reg     <= fib_a_next;
      fib_b_reg     <= fib_b_next;
      halted_reg    <= halted_next;
      done_reg      <= done_next;
      pass_reg      <= pass_next;
      timeout_reg   <= timeout_next;
      err_cnt_reg   <= err_cnt_next;
      first_err_reg <= first_err_next;
    end
  end

  assign chk_rd_en_o     = rd_en_reg;
  assign chk_addr_o      = addr_reg;
  assign halted_o        = halted_reg;
  assign done_o          = done_reg;
  assign pass_o          = pass_reg;
  assign timeout_o       = timeout_reg;
  assign err_cnt_o       = err_cnt_reg;
  assign first_err_idx_o = first_err_reg;

endmodule

// File: tb/tb_fib_result_checker.sv
// Bench for fib_result_checker: a 10-term and a 50-term (wrap-around) checker
// share one PC stream and one result memory.
`timescale 1ns/1ps
module tb_fib_result_checker;

  localparam int N10    = 10;
  localparam int N50    = 50;
  localparam int HALT   = 104;
  localparam int STABLE = 10;
  localparam int TMO    = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc  = '0;
  logic        rd_en_a, rd_en_b;
  logic [31:0] addr_a, addr_b;
  logic [31:0] rdata_a = '0;
  logic [31:0] rdata_b = '0;
  logic        halted_a, done_a, pass_a, to_a;
  logic        halted_b, done_b, pass_b, to_b;
  logic [7:0]  err_a, first_a, err_b, first_b;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_fib [0:63];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Result memory with one-cycle registered read per checker
  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= mem[addr_a[7:2]];
    if (rd_en_b) rdata_b <= mem[addr_b[7:2]];
  end

  fib_result_checker #(
    .DATA_W(32), .ADDR_W(32), .N_TERMS(N10), .BASE_ADDR(0), .HALT_PC(HALT),
    .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)
  ) dut_a (
    .clk(clk), .rst(rst), .pc_i(pc), .chk_rd_en_o(rd_en_a), .chk_addr_o(addr_a),
    .chk_rdata_i(rdata_a), .halted_o(halted_a), .done_o(done_a), .pass_o(pass_a),
    .timeout_o(to_a), .err_cnt_o(err_a), .first_err_idx_o(first_a)
  );

  fib_result_checker #(
    .DATA_W(32), .ADDR_W(32), .N_TERMS(N50), .BASE_ADDR(0), .HALT_PC(HALT),
    .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)
  ) dut_b (
    .clk(clk), .rst(rst), .pc_i(pc), .chk_rd_en_o(rd_en_b), .chk_addr_o(addr_b),
    .chk_rdata_i(rdata_b), .halted_o(halted_b), .done_o(done_b), .pass_o(pass_b),
    .timeout_o(to_b), .err_cnt_o(err_b), .first_err_idx_o(first_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_good();
    for (int k = 0; k < 64; k++) mem[k] = ref_fib[k];
  endtask

  // Fibonacci reference with fib(0)=fib(1)=1, wrapped to 32 bits
  task automatic build_ref();
    longint s;
    ref_fib[0] = 32'd1;
    ref_fib[1] = 32'd1;
    for (int k = 2; k < 64; k++) begin
      s = longint'(ref_fib[k-1]) + longint'(ref_fib[k-2]);
      ref_fib[k] = s[31:0];
    end
  endtask

  task automatic test_reset();
    pc  = HALT;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (halted_a !== 1'b0 || halted_b !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b/%b expected 0", halted_a, halted_b); end
    n_cmp++; if (done_a !== 1'b0 || pass_a !== 1'b0 || to_a !== 1'b0) begin n_bad++; $display("FAIL reset_flags: done=%b pass=%b to=%b expected 0", done_a, pass_a, to_a); end
    n_cmp++; if (err_a !== 8'd0 || first_a !== 8'hFF) begin n_bad++; $display("FAIL reset_err: err=%0d first=%0h expected 0/ff", err_a, first_a); end
    n_cmp++; if (rd_en_a !== 1'b0 || rd_en_b !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b/%b expected 0", rd_en_a, rd_en_b); end
    $display("reset: halted=%b done=%b err=%0d first=%0h", halted_a, done_a, err_a, first_a);
    rst = 1'b0;
    pc  = '0;
  endtask

  // Reset, wander, park the PC on HALT and check timing, read stream and verdicts
  task automatic run_scan(input string tag);
    int ha, da, db, w;
    int ea, fa, eb, fb;
    logic        exp_en;
    logic [31:0] exp_addr;
    ha = -1; da = -1; db = -1;
    pc = '0;
    do_reset();
    w = $urandom_range(0, 20);
    repeat (w) begin
      pc = 32'($urandom_range(0, 25) * 4);
      tick();
    end
    pc = HALT;
    for (int e = 1; e <= 70; e++) begin
      tick();
      if (halted_a && ha < 0) ha = e;
      if (done_a && da < 0) da = e;
      if (done_b && db < 0) db = e;
      if (e >= STABLE + 1 && e <= STABLE + N10 + 1) begin
        exp_en   = (e <= STABLE + N10);
        exp_addr = 32'((e - STABLE - 1) * 4);
        n_cmp++;
        if (rd_en_a !== exp_en || (exp_en && addr_a !== exp_addr)) begin
          n_bad++;
          $display("FAIL %s_read e=%0d: en=%b addr=%0d expected en=%b addr=%0d", tag, e, rd_en_a, addr_a, exp_en, exp_addr);
        end
      end
    end
    ea = 0; fa = 255; eb = 0; fb = 255;
    for (int k = 0; k < N50; k++) begin
      if (mem[k] !== ref_fib[k]) begin
        if (k < N10) begin ea++; if (fa == 255) fa = k; end
        eb++; if (fb == 255) fb = k;
      end
    end
    n_cmp++; if (ha != STABLE + 1) begin n_bad++; $display("FAIL %s_halt_time: got %0d expected %0d", tag, ha, STABLE + 1); end
    n_cmp++; if (da != STABLE + 1 + N10 + 1) begin n_bad++; $display("FAIL %s_done_time_a: got %0d expected %0d", tag, da, STABLE + N10 + 2); end
    n_cmp++; if (db != STABLE + 1 + N50 + 1) begin n_bad++; $display("FAIL %s_done_time_b: got %0d expected %0d", tag, db, STABLE + N50 + 2); end
    n_cmp++; if (err_a !== 8'(ea) || first_a !== 8'(fa)) begin n_bad++; $display("FAIL %s_err_a: err=%0d first=%0d expected %0d/%0d", tag, err_a, first_a, ea, fa); end
    n_cmp++; if (pass_a !== (ea == 0) || done_a !== 1'b1 || to_a !== 1'b0) begin n_bad++; $display("FAIL %s_pass_a: pass=%b done=%b to=%b expected pass=%b", tag, pass_a, done_a, to_a, (ea == 0)); end
    n_cmp++; if (err_b !== 8'(eb) || first_b !== 8'(fb)) begin n_bad++; $display("FAIL %s_err_b: err=%0d first=%0d expected %0d/%0d", tag, err_b, first_b, eb, fb); end
    n_cmp++; if (pass_b !== (eb == 0) || done_b !== 1'b1) begin n_bad++; $display("FAIL %s_pass_b: pass=%b done=%b expected pass=%b", tag, pass_b, done_b, (eb == 0)); end
    $display("scan %s: a err=%0d first=%0d pass=%b | b err=%0d first=%0d pass=%b", tag, err_a, first_a, pass_a, err_b, first_b, pass_b);
  endtask

  task automatic test_correct();
    load_good();
    run_scan("correct");
  endtask

  task automatic test_single_corrupt();
    load_good();
    mem[5] = 32'd9;
    run_scan("word5");
  endtask

  task automatic test_random_corrupt();
    int idx;
    for (int r = 0; r < 4; r++) begin
      load_good();
      repeat ($urandom_range(1, 3)) begin
        idx = $urandom_range(0, N50 - 1);
        mem[idx] = ref_fib[idx] ^ (32'd1 << $urandom_range(0, 31));
      end
      run_scan($sformatf("rand%0d", r));
    end
  endtask

  task automatic test_wrap();
    load_good();
    run_scan("wrap50");
  endtask

  task automatic test_branch();
    load_good();
    pc = '0;
    do_reset();
    repeat (20) begin
      pc = HALT; tick();
      pc = 32'd28; tick();
    end
    n_cmp++; if (halted_a !== 1'b0 || rd_en_a !== 1'b0) begin n_bad++; $display("FAIL branch_single: halted=%b rd_en=%b expected 0", halted_a, rd_en_a); end
    pc = HALT;
    repeat (9) tick();
    pc = 32'd28;
    repeat (5) tick();
    n_cmp++; if (halted_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL branch_nine: halted=%b done=%b expected 0", halted_a, done_a); end
    $display("branch: halted=%b done=%b", halted_a, done_a);
  endtask

  task automatic test_timeout();
    pc = '0;
    do_reset();
`ifdef FIB_RESULT_CHECKER_TIMEOUT_EN
    repeat (TMO - 1) tick();
    n_cmp++; if (to_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL timeout_early: to=%b done=%b expected 0", to_a, done_a); end
    tick();
    n_cmp++; if (to_a !== 1'b1 || done_a !== 1'b1 || pass_a !== 1'b0) begin n_bad++; $display("FAIL timeout_at: to=%b done=%b pass=%b expected 1/1/0", to_a, done_a, pass_a); end
    n_cmp++; if (to_b !== 1'b1 || halted_a !== 1'b0 || first_a !== 8'hFF) begin n_bad++; $display("FAIL timeout_other: to_b=%b halted=%b first=%0h expected 1/0/ff", to_b, halted_a, first_a); end
    pc = HALT;
    repeat (20) tick();
    n_cmp++; if (halted_a !== 1'b0 || rd_en_a !== 1'b0 || to_a !== 1'b1) begin n_bad++; $display("FAIL timeout_hold: halted=%b rd_en=%b to=%b expected 0/0/1", halted_a, rd_en_a, to_a); end
`else
    repeat (5000) tick();
    n_cmp++; if (done_a !== 1'b0 || to_a !== 1'b0 || done_b !== 1'b0) begin n_bad++; $display("FAIL no_timeout: done=%b to=%b done_b=%b expected 0", done_a, to_a, done_b); end
`endif
    $display("timeout: to=%b done=%b pass=%b", to_a, done_a, pass_a);
    pc = '0;
  endtask

  task automatic test_reset_mid_scan();
    int found;
    load_good();
    pc = '0;
    do_reset();
    pc = HALT;
    found = 0;
    for (int e = 0; e < 40 && found == 0; e++) begin
      tick();
      if (rd_en_a && addr_a == 32'd16) found = 1;
    end
    n_cmp++; if (found != 1) begin n_bad++; $display("FAIL midscan_read4: found=%0d expected 1", found); end
    rst = 1'b1;
    tick();
    n_cmp++; if (rd_en_a !== 1'b0 || halted_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin n_bad++; $display("FAIL midscan_flags: rd_en=%b halted=%b done=%b pass=%b expected 0", rd_en_a, halted_a, done_a, pass_a); end
    n_cmp++; if (err_a !== 8'd0 || first_a !== 8'hFF || addr_a !== 32'd0) begin n_bad++; $display("FAIL midscan_regs: err=%0d first=%0h addr=%0d expected 0/ff/0", err_a, first_a, addr_a); end
    $display("midscan reset: halted=%b rd_en=%b addr=%0d", halted_a, rd_en_a, addr_a);
    rst = 1'b0;
    run_scan("after_reset");
  endtask

  initial begin
    build_ref();
    load_good();
    test_reset();
    test_correct();
    test_single_corrupt();
    test_branch();
    test_timeout();
    test_reset_mid_scan();
    test_random_corrupt();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
